// File: rtl/i2c_slave_seq.sv
// I2C slave byte sequencer: address match, receive and transmit bytes with ACK handling.
// Works from pre-detected SCL edges and START/STOP strobes; drives SDA as open-drain enable.
module i2c_slave_seq #(
  parameter logic [6:0] OWN_ADDR = 7'h42,
  parameter int         WIDTH    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scl_rise_i,
  input  logic             scl_fall_i,
  input  logic             start_det_i,
  input  logic             stop_det_i,
  input  logic             sda_i,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             tx_req_o,
  output logic             sda_oe_o,
  output logic             ser_en_o,
  output logic             deser_en_o,
  output logic             busy_o,
  output logic             addr_match_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh, tx_sh, sh_n, ld;
  logic             rw, byte_done, ack_ok;
  logic [2:0]       en;

  assign sh_n = {sh[WIDTH-2:0], sda_i};
  assign ld   = tx_valid_i ? tx_data_i : '1;
  assign {busy_o, ser_en_o, deser_en_o} = en;

  // {busy, ser_en, deser_en} for a state, registered alongside the state itself
  function automatic logic [2:0] en_of(state_t s);
    return {s != IDLE, s == TX_DATA, (s == ADDR) || (s == RX_DATA)};
  endfunction

  always_ff @(posedge clk_i) begin
    rx_valid_o <= 1'b0;
    tx_req_o   <= 1'b0;
    if (rst_i) begin
      state <= IDLE; en <= '0; cnt <= '0; sh <= '0; tx_sh <= '0;
      rw <= 1'b0; byte_done <= 1'b0; ack_ok <= 1'b0;
      sda_oe_o <= 1'b0; addr_match_o <= 1'b0; rx_data_o <= '0;
    end else if (start_det_i) begin
      state <= ADDR; en <= en_of(ADDR); cnt <= '0; sh <= '0;
      byte_done <= 1'b0; ack_ok <= 1'b0; sda_oe_o <= 1'b0; addr_match_o <= 1'b0;
    end else if (stop_det_i) begin
      state <= IDLE; en <= en_of(IDLE);
      byte_done <= 1'b0; ack_ok <= 1'b0; sda_oe_o <= 1'b0; addr_match_o <= 1'b0;
    end else if (scl_rise_i) begin
      // a simultaneous fall strobe is deliberately dropped here
      case (state)
        ADDR, RX_DATA: begin
          sh  <= sh_n;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            cnt <= '0;
            if (state == RX_DATA) begin
              rx_data_o <= sh_n; rx_valid_o <= 1'b1; byte_done <= 1'b1;
            end else if (sh_n[7:1] == OWN_ADDR) begin
              byte_done <= 1'b1; rw <= sh_n[0];
            end else begin
              state <= WAIT_STOP; en <= en_of(WAIT_STOP);
            end
          end
        end
        TX_ACK: begin
          if (sda_i) begin
            state <= WAIT_STOP; en <= en_of(WAIT_STOP);
          end else begin
            ack_ok <= 1'b1; tx_req_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end else if (scl_fall_i) begin
      case (state)
        ADDR: if (byte_done) begin
          byte_done <= 1'b0; sda_oe_o <= 1'b1; addr_match_o <= 1'b1; tx_req_o <= rw;
          state <= ADDR_ACK; en <= en_of(ADDR_ACK);
        end
        ADDR_ACK: begin
          if (rw) begin
            tx_sh <= ld << 1; sda_oe_o <= ~ld[WIDTH-1]; cnt <= '0;
            state <= TX_DATA; en <= en_of(TX_DATA);
          end else begin
            sda_oe_o <= 1'b0; state <= RX_DATA; en <= en_of(RX_DATA);
          end
        end
        RX_DATA: if (byte_done) begin
          byte_done <= 1'b0; sda_oe_o <= 1'b1;
          state <= RX_ACK; en <= en_of(RX_ACK);
        end
        RX_ACK: begin
          sda_oe_o <= 1'b0; state <= RX_DATA; en <= en_of(RX_DATA);
        end
        TX_DATA: begin
          if (cnt == CW'(WIDTH-1)) begin
            sda_oe_o <= 1'b0; cnt <= '0;
            state <= TX_ACK; en <= en_of(TX_ACK);
          end else begin
            sda_oe_o <= ~tx_sh[WIDTH-1]; tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
            cnt <= cnt + CW'(1);
          end
        end
        TX_ACK: if (ack_ok) begin
          ack_ok <= 1'b0; tx_sh <= ld << 1; sda_oe_o <= ~ld[WIDTH-1]; cnt <= '0;
          state <= TX_DATA; en <= en_of(TX_DATA);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/i2c_slave_seq.md
I2C_SLAVE_SEQ -- requirements
Module: i2c_slave_seq

Parameters
REQ-001 SHALL have parameter OWN_ADDR, default 7'h42, the 7-bit slave address matched against the address byte.
REQ-002 SHALL have parameter WIDTH, default 8, the bits per transfer byte.

Interface
REQ-003 clk_i  input  1  system clock; all logic on its rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 scl_rise_i / scl_fall_i  input  1 each  single-cycle SCL edge strobes, synchronous to clk_i.
REQ-006 start_det_i / stop_det_i  input  1 each  single-cycle START/STOP condition strobes.
REQ-007 sda_i  input  1  synchronized SDA level.
REQ-008 tx_data_i  input  WIDTH  next byte to transmit; tx_valid_i  input  1  tx_data_i is valid.
REQ-009 rx_data_o  output  WIDTH  last received data byte; rx_valid_o  output  1  one-cycle strobe for rx_data_o.
REQ-010 tx_req_o  output  1  one-cycle request for the next tx byte.
REQ-011 sda_oe_o  output  1  1 = pull SDA low (open drain), 0 = release.
REQ-012 ser_en_o / deser_en_o  output  1 each  serialiser / deserialiser enables.
REQ-013 busy_o  output  1  state != IDLE; addr_match_o  output  1  high from address ACK until STOP or START.

Function
REQ-014 FSM states SHALL be: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
REQ-015 SDA SHALL be sampled only on scl_rise_i; sda_oe_o SHALL change only on scl_fall_i, start_det_i, stop_det_i or reset.
REQ-016 start_det_i in any state SHALL enter ADDR, clear the bit counter and shift register, set sda_oe_o=0 and clear addr_match_o; this also covers repeated START.
REQ-017 stop_det_i in any state SHALL enter IDLE with sda_oe_o=0; if it arrives in the same cycle as start_det_i, start_det_i wins.
REQ-018 If scl_rise_i and scl_fall_i arrive in the same cycle, rise SHALL be processed and fall ignored.
REQ-019 ADDR: shift in MSB-first on each rise. After the 8th rise, compare shift[7:1] with OWN_ADDR.
  - Match: at the next fall, set sda_oe_o=1, set addr_match_o=1 and enter ADDR_ACK, latching R/W=shift[0].
  - Mismatch: enter WAIT_STOP; sda_oe_o stays 0.
REQ-020 Entering ADDR_ACK with R/W=1 SHALL pulse tx_req_o for one cycle.
REQ-021 ADDR_ACK, at the next fall:
  - W: release SDA and enter RX_DATA.
  - R: load tx_data_i if tx_valid_i=1, else 8'hFF; drive bit7 (sda_oe_o = ~bit); enter TX_DATA.
REQ-022 RX_DATA: after the 8th rise, update rx_data_o and pulse rx_valid_o one cycle. At the next fall, set sda_oe_o=1 and enter RX_ACK. At the following fall, release SDA and return to RX_DATA.
REQ-023 TX_DATA: each fall shifts out the next bit. The fall after the 8th bit releases SDA and enters TX_ACK.
REQ-024 TX_ACK: sample at rise.
  - sda_i=0 (ACK): pulse tx_req_o, then at the next fall load and drive the next byte as in REQ-021 and enter TX_DATA.
  - sda_i=1 (NACK): enter WAIT_STOP.
REQ-025 WAIT_STOP SHALL ignore SCL strobes and keep sda_oe_o=0.
REQ-026 Enable outputs:
  - deser_en_o = 1 in ADDR and RX_DATA.
  - ser_en_o = 1 in TX_DATA.
  - busy_o = 1 in all states except IDLE.
REQ-027 Bit counter SHALL be 3 bits for WIDTH=8 and wrap 7->0 at byte end; it never exceeds WIDTH-1.
REQ-028 Latency: rx_valid_o SHALL assert on the clk_i cycle after the 8th data scl_rise_i.

Reset
REQ-029 rst_i=1 SHALL force IDLE on the next clk_i edge. Every output SHALL then be 0: sda_oe_o, rx_valid_o, tx_req_o, ser_en_o, deser_en_o, busy_o, addr_match_o, and rx_data_o=0.
REQ-030 Reset mid-transfer SHALL abandon the transfer. No rx_valid_o or tx_req_o pulse SHALL follow. The block waits for a new start_det_i.

Verification
REQ-031 Write: START, addr 0x84 (0x42,W), data 0xA5 -> sda_oe_o=1 in both ACK slots, rx_data_o=0xA5 with one rx_valid_o pulse, busy_o=1 until STOP.
REQ-032 Read: START, addr 0x85, tx_data_i=0x3C valid, master ACK then NACK -> bit pattern 0,0,1,1,1,1,0,0 on ~sda_oe_o, two tx_req_o pulses, then WAIT_STOP.
REQ-033 Address mismatch: START, addr 0x86 -> sda_oe_o never asserts, addr_match_o=0, state WAIT_STOP until STOP, then IDLE.
REQ-034 Repeated START after the write ACK, then addr 0x85 -> ADDR re-entered, counter cleared, read proceeds correctly.
REQ-035 rst_i=1 after the 4th data bit of a write -> all outputs 0 next cycle, no rx_valid_o; next START/0x84 transfer succeeds.
REQ-036 tx_valid_i=0 at load -> 0xFF transmitted (sda_oe_o=0 for all 8 bits).
